// File: rtl/video_pkg.sv
// Shared definitions for the video timing generator.
// hve bit positions and display mode presets.
package video_pkg;

  localparam int HVE_HS = 2;
  localparam int HVE_VS = 1;
  localparam int HVE_DE = 0;

  typedef struct packed {
    int active;
    int fp;
    int sync;
    int bp;
  } timing_t;

  localparam timing_t MODE_480P60_H = '{
    active: 640, fp: 16, sync: 96, bp: 48
  };
  localparam timing_t MODE_480P60_V = '{
    active: 480, fp: 10, sync: 2, bp: 33
  };

  localparam timing_t MODE_720P60_H = '{
    active: 1280, fp: 110, sync: 40, bp: 220
  };
  localparam timing_t MODE_720P60_V = '{
    active: 720, fp: 5, sync: 5, bp: 20
  };

  localparam timing_t MODE_1080P30_H = '{
    active: 1920, fp: 88, sync: 44, bp: 148
  };
  localparam timing_t MODE_1080P30_V = '{
    active: 1080, fp: 4, sync: 5, bp: 36
  };

endpackage

// File: rtl/timing_axis.sv
// One timing axis: signed counter from -blank to active-1
// with registered sync flag and next-state lookahead.
module timing_axis #(
  parameter int ACTIVE = 1280,
  parameter int FP     = 110,
  parameter int SYNC   = 40,
  parameter int BP     = 220,
  parameter int W      = 13,
  parameter bit POL    = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en_i,
  input  logic                step_i,
  output logic signed [W-1:0] count_o,
  output logic                sync_o,
  output logic                act_nxt_o,
  output logic                head_o,
  output logic                wrap_o
);

  localparam int BLANK = FP + SYNC + BP;

  localparam logic signed [W-1:0] FIRST   = W'(-BLANK);
  localparam logic signed [W-1:0] LAST    = W'(ACTIVE - 1);
  localparam logic signed [W-1:0] SYNC_LO = W'(FP - BLANK);
  localparam logic signed [W-1:0] SYNC_HI = W'(-BP - 1);
  localparam logic signed [W-1:0] ONE     = W'(1);

  if ((ACTIVE - 1) >= 2 ** (W - 1) ||
      BLANK > 2 ** (W - 1)) begin : g_range
    $error("timing_axis: W=%0d too narrow", W);
  end

  logic signed [W-1:0] cnt_q, cnt_d;
  logic                sync_q, sync_d;

  assign wrap_o = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (en_i && step_i) begin
      cnt_d = wrap_o ? FIRST : cnt_q + ONE;
    end
    sync_d = ((cnt_d >= SYNC_LO) &&
              (cnt_d <= SYNC_HI)) ^ ~POL;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= FIRST;
      sync_q <= ~POL;
    end else begin
      cnt_q  <= cnt_d;
      sync_q <= sync_d;
    end
  end

  assign count_o   = cnt_q;
  assign sync_o    = sync_q;
  assign act_nxt_o = ~cnt_d[W-1];
  assign head_o    = (cnt_d == FIRST);

endmodule

// File: rtl/video_timing_gen.sv
// Parametrised display timing source: hve bundle, signed
// beam coordinates, line/frame strobes and frame counter.
module video_timing_gen
  import video_pkg::*;
#(
  parameter int H_ACTIVE  = MODE_720P60_H.active,
  parameter int H_FP      = MODE_720P60_H.fp,
  parameter int H_SYNC    = MODE_720P60_H.sync,
  parameter int H_BP      = MODE_720P60_H.bp,
  parameter int V_ACTIVE  = MODE_720P60_V.active,
  parameter int V_FP      = MODE_720P60_V.fp,
  parameter int V_SYNC    = MODE_720P60_V.sync,
  parameter int V_BP      = MODE_720P60_V.bp,
  parameter bit HSYNC_POL = 1'b1,
  parameter bit VSYNC_POL = 1'b1,
  parameter int COORD_W   = 13,
  parameter int FCNT_W    = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      i_enable,
  output logic [2:0]                o_hve,
  output logic signed [COORD_W-1:0] o_x,
  output logic signed [COORD_W-1:0] o_y,
  output logic                      o_line_start,
  output logic                      o_frame_start,
  output logic [FCNT_W-1:0]         o_frame_count
);

  logic run_q, ls_q, fs_q, de_q;
  logic [FCNT_W-1:0] fc_q;

  logic adv;
  logic h_wrap, v_wrap;
  logic h_head, v_head;
  logic h_act, v_act;
  logic h_sync, v_sync;

  // The first enabled edge after reset or a hold re-presents
  // the current pixel; only later enabled edges advance.
  assign adv = i_enable & run_q;

  timing_axis #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP),
    .W      (COORD_W),
    .POL    (HSYNC_POL)
  ) u_h (
    .clk       (clk),
    .reset     (reset),
    .en_i      (adv),
    .step_i    (1'b1),
    .count_o   (o_x),
    .sync_o    (h_sync),
    .act_nxt_o (h_act),
    .head_o    (h_head),
    .wrap_o    (h_wrap)
  );

  timing_axis #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP),
    .W      (COORD_W),
    .POL    (VSYNC_POL)
  ) u_v (
    .clk       (clk),
    .reset     (reset),
    .en_i      (adv),
    .step_i    (h_wrap),
    .count_o   (o_y),
    .sync_o    (v_sync),
    .act_nxt_o (v_act),
    .head_o    (v_head),
    .wrap_o    (v_wrap)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run_q <= 1'b0;
      ls_q  <= 1'b0;
      fs_q  <= 1'b0;
      de_q  <= 1'b0;
      fc_q  <= '0;
    end else begin
      run_q <= i_enable;
      ls_q  <= i_enable & h_head;
      fs_q  <= i_enable & h_head & v_head;
      de_q  <= h_act & v_act;
      if (adv && h_wrap && v_wrap) begin
        fc_q <= fc_q + FCNT_W'(1);
      end
    end
  end

  assign o_hve[HVE_HS] = h_sync;
  assign o_hve[HVE_VS] = v_sync;
  assign o_hve[HVE_DE] = de_q;

  assign o_line_start  = ls_q;
  assign o_frame_start = fs_q;
  assign o_frame_count = fc_q;

endmodule
